mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Memory-stage controller that consumes the registered EXE→MEM pipeline outputs and performs 32-bit word loads/stores on an external 16-bit asynchronous SRAM as two half-word accesses. While an access is in progress it drops `ready`; the top level drives the pipeline `freeze` from `~ready`, holding all stage registers. It returns the loaded word to the MEM→WB register.

## Interface
- `WAIT_CYCLES`, default 2: cycles per half-word access; legal minimum 2.
- `BASE_ADDR`, default 32'd1024: data-memory base subtracted from the ALU address.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `mem_r_en`  in  1  load request; held stable by the frozen pipeline until `ready`
- `mem_w_en`  in  1  store request; same hold rule
- `alu_result`  in  32  byte address
- `st_val`  in  32  store data
- `ready`  out  1  0 while a request is being serviced
- `read_data`  out  32  last completed load word
- `sram_addr`  out  18  half-word address
- `sram_dq_out`  out  16  write data
- `sram_dq_oe`  out  1  1 = controller drives the DQ bus (tri-state at top)
- `sram_dq_in`  in  16  read data from the DQ bus
- `sram_we_n`, `sram_oe_n`  out  1 each  active-low write and output enables
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  held 0

## Operation
- Word address `wa = (alu_result - BASE_ADDR) mod 2^32, bits [18:2]` (17 bits). Low half at `{wa,1'b0}`; high half at `{wa,1'b1}`. Bits [1:0] are ignored, and out-of-range addresses wrap silently.
- Request `req = mem_r_en | mem_w_en`. If both are set, perform a store and do not update `read_data`.
- FSM states: IDLE, LOW, HIGH, DONE. A counter `cnt` runs from 0 to WAIT_CYCLES-1 within LOW and HIGH.
  - IDLE: if `req`, latch the op (write/read), `wa`, and `st_val`, then go to LOW with `cnt=0`. Otherwise stay in IDLE.
  - LOW: `sram_addr={wa,0}`. On `cnt==WAIT_CYCLES-1`, go to HIGH with `cnt=0`.
  - HIGH: `sram_addr={wa,1}`. On last `cnt`, go to DONE.
  - DONE: go to IDLE unconditionally.
- `ready = ~(req & state!=DONE)`. This is combinational, so it is 0 in the IDLE cycle that sees a new request.
- Store in LOW or HIGH:
  - `sram_dq_oe=1`.
  - `sram_dq_out` = latched `st_val[15:0]` in LOW, `[31:16]` in HIGH.
  - `sram_we_n=0` for `cnt<WAIT_CYCLES-1`, and 1 on the last cycle of each phase (data hold).
  - `sram_oe_n=1`.
- Load in LOW or HIGH:
  - `sram_oe_n=0`, `sram_we_n=1`, `dq_oe=0`.
  - On the last `cnt` of LOW, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last `cnt` of HIGH, capture into `[31:16]`.
- IDLE and DONE: `we_n=1`, `oe_n=1`, `dq_oe=0`, `sram_addr` = latched value (0 after reset).
- `read_data` is held between loads. Stores never modify it.

## Timing
- Reset values:
  - state IDLE, `cnt=0`, latched address/data/op 0.
  - `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`.
  - `sram_we_n=1`, `sram_oe_n=1`.
  - `ready=~req` (IDLE).
- Access occupies 1 + 2·WAIT_CYCLES cycles with `ready=0`, then 1 DONE cycle with `ready=1`. With WAIT_CYCLES=2, that is 5 frozen cycles and the pipeline advances at the 6th edge.
- `read_data` is valid (complete word) from the first cycle of DONE.
- A back-to-back request is first seen in the IDLE cycle after DONE. There are no zero-gap accesses.
- Inputs change after DONE have no effect on the completed access. Inputs are sampled only in IDLE.
- Reset mid-access:
  - immediate return to IDLE.
  - `we_n`/`oe_n` deasserted and `dq_oe=0` asynchronously.
  - `read_data` cleared.
  - the partial store is not retried.

## Test plan
- Reset, no request: `ready=1`, `we_n=oe_n=1`, `dq_oe=0`, `read_data=0` indefinitely.
- Store `alu_result=1028`, `st_val=32'hDEADBEEF`, WAIT=2:
  - `ready` low exactly 5 cycles.
  - `sram_addr` is 2 with DQ 16'hBEEF, then 3 with DQ 16'hDEAD.
  - `we_n` pulses low 1 cycle per half.
- Load `alu_result=1028` with SRAM model returning the prior store: `read_data=32'hDEADBEEF` in DONE and held after `mem_r_en` drops.
- Back-to-back load at 1024 then store at 1032: two separate 5-cycle freezes separated by one `ready=1` DONE cycle plus a `ready=0` IDLE cycle. Second access uses `sram_addr` 4/5.
- Both enables high at `alu_result=1024`: store performed at addresses 0/1, and `read_data` unchanged.
- Assert `rst` during HIGH of a store: `we_n=1` and `dq_oe=0` immediately. After release, `ready=1` with no request, and the next load at the same address completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: performs 32-bit loads/stores on a 16-bit asynchronous SRAM
// as two half-word accesses, holding the pipeline (ready=0) while an access is in flight.
module mem_stage_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] read_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CntW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [16:0]     wa_q, wa_d;
  logic [31:0]     st_val_q, st_val_d;
  logic [31:0]     read_data_q, read_data_d;
  logic [17:0]     addr_hold_q;

  logic        req;
  logic        last;
  logic [18:0] offset;
  logic [16:0] wa_in;
  logic        unused_offset_bits;

  // Only bits [18:2] of the rebased address matter; higher bits wrap silently.
  assign offset             = alu_result[18:0] - BASE_ADDR[18:0];
  assign wa_in              = offset[18:2];
  assign unused_offset_bits = ^{offset[1:0], alu_result[31:19]};

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt_q == CntLast);

  assign ready     = ~(req & (state_q != StDone));
  assign read_data = read_data_q;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wa_d        = wa_q;
    st_val_d    = st_val_q;
    read_data_d = read_data_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req) begin
          write_d  = mem_w_en;
          wa_d     = wa_in;
          st_val_d = st_val;
          state_d  = StLow;
        end
      end
      StLow: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (!write_q) read_data_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!write_q) read_data_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs decode straight from state so reset releases them asynchronously.
  always_comb begin
    sram_addr   = addr_hold_q;
    sram_dq_out = 16'h0000;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state_q == StLow || state_q == StHigh) begin
      sram_addr = {wa_q, (state_q == StHigh)};
      if (write_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == StHigh) ? st_val_q[31:16] : st_val_q[15:0];
        sram_we_n   = last;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wa_q        <= '0;
      st_val_q    <= '0;
      read_data_q <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wa_q        <= wa_d;
      st_val_q    <= st_val_d;
      read_data_q <= read_data_d;
      addr_hold_q <= sram_addr;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM model.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] st_val = '0;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:255];

  logic [17:0] s_addr  [0:5];
  logic [15:0] s_dq    [0:5];
  logic        s_ready [0:5];
  logic        s_we    [0:5];
  logic        s_oe    [0:5];
  logic        s_dqoe  [0:5];
  logic [31:0] s_rd    [0:5];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .alu_result (alu_result),
    .st_val     (st_val),
    .ready      (ready),
    .read_data  (read_data),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
  end

  task automatic sample(input int i);
    s_addr[i]  = sram_addr;
    s_dq[i]    = sram_dq_out;
    s_ready[i] = ready;
    s_we[i]    = sram_we_n;
    s_oe[i]    = sram_oe_n;
    s_dqoe[i]  = sram_dq_oe;
    s_rd[i]    = read_data;
  endtask

  // Drive a request in an IDLE cycle and sample IDLE, four phase cycles, and DONE.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    mem_r_en = r; mem_w_en = w; alu_result = a; st_val = d;
    #1 sample(0);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      sample(i);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus: we_n=%b oe_n=%b dq_oe=%b want 1 1 0", sram_we_n, sram_oe_n,
               sram_dq_oe);
    end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      vectors++;
      if (ready !== 1'b1 || read_data !== 32'h0 || sram_addr !== 18'h0 ||
          sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
          sram_ce_n !== 1'b0 || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: ready=%b rd=%h addr=%h we_n=%b oe_n=%b dq_oe=%b", i,
                 ready, read_data, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe);
      end
    end
  endtask

  task automatic test_store();
    int frozen;
    run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    frozen = 0;
    for (int i = 0; i < 6; i++) if (s_ready[i] === 1'b0) frozen++;
    vectors++;
    if (frozen != 5 || s_ready[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL store_freeze: frozen=%0d done_ready=%b want 5 1", frozen, s_ready[5]);
    end
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (s_addr[i] !== ((i < 3) ? 18'd2 : 18'd3) ||
          s_dq[i] !== ((i < 3) ? 16'hBEEF : 16'hDEAD) ||
          s_we[i] !== ((i == 1 || i == 3) ? 1'b0 : 1'b1) ||
          s_dqoe[i] !== 1'b1 || s_oe[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL store_phase[%0d]: addr=%0d dq=%h we_n=%b dq_oe=%b oe_n=%b", i, s_addr[i],
                 s_dq[i], s_we[i], s_dqoe[i], s_oe[i]);
      end
    end
    vectors++;
    if (s_we[5] !== 1'b1 || s_dqoe[5] !== 1'b0 || s_addr[5] !== 18'd3 || s_rd[5] !== 32'h0) begin
      miscompares++;
      $display("FAIL store_done: we_n=%b dq_oe=%b addr=%0d rd=%h want 1 0 3 0", s_we[5],
               s_dqoe[5], s_addr[5], s_rd[5]);
    end
    mem_w_en = 1'b0;
    next_cycle();
    vectors++;
    if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL store_mem: mem2=%h mem3=%h want beef dead", mem[2], mem[3]);
    end
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (s_ready[i] !== 1'b0 || s_oe[i] !== 1'b0 || s_we[i] !== 1'b1 || s_dqoe[i] !== 1'b0 ||
          s_addr[i] !== ((i < 3) ? 18'd2 : 18'd3)) begin
        miscompares++;
        $display("FAIL load_phase[%0d]: ready=%b oe_n=%b we_n=%b dq_oe=%b addr=%0d", i,
                 s_ready[i], s_oe[i], s_we[i], s_dqoe[i], s_addr[i]);
      end
    end
    vectors++;
    if (s_ready[0] !== 1'b0 || s_ready[5] !== 1'b1 || s_rd[5] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL load_done: idle_ready=%b done_ready=%b rd=%h want 0 1 deadbeef",
               s_ready[0], s_ready[5], s_rd[5]);
    end
    mem_r_en = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    vectors++;
    if (read_data !== 32'hDEADBEEF || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_hold: rd=%h ready=%b want deadbeef 1", read_data, ready);
    end
  endtask

  task automatic test_back_to_back();
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0);
    vectors++;
    if (s_ready[5] !== 1'b1 || s_rd[5] !== 32'h56781234 || s_addr[1] !== 18'd0 ||
        s_addr[3] !== 18'd1) begin
      miscompares++;
      $display("FAIL b2b_first: ready=%b rd=%h addr_lo=%0d addr_hi=%0d want 1 56781234 0 1",
               s_ready[5], s_rd[5], s_addr[1], s_addr[3]);
    end
    // Pipeline advances during DONE; the new request waits for the following IDLE cycle.
    next_cycle();
    run_access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
    vectors++;
    if (s_ready[0] !== 1'b0 || s_ready[4] !== 1'b0 || s_ready[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_ready: idle=%b h1=%b done=%b want 0 0 1", s_ready[0],
               s_ready[4], s_ready[5]);
    end
    vectors++;
    if (s_addr[1] !== 18'd4 || s_addr[2] !== 18'd4 || s_addr[3] !== 18'd5 ||
        s_addr[4] !== 18'd5) begin
      miscompares++;
      $display("FAIL b2b_addr: %0d %0d %0d %0d want 4 4 5 5", s_addr[1], s_addr[2], s_addr[3],
               s_addr[4]);
    end
    mem_w_en = 1'b0;
    next_cycle();
    vectors++;
    if (mem[4] !== 16'hF00D || mem[5] !== 16'hCAFE || read_data !== 32'h56781234) begin
      miscompares++;
      $display("FAIL b2b_mem: mem4=%h mem5=%h rd=%h want f00d cafe 56781234", mem[4], mem[5],
               read_data);
    end
  endtask

  task automatic test_both_enables();
    run_access(1'b1, 1'b1, 32'd1024, 32'h11112222);
    vectors++;
    if (s_we[1] !== 1'b0 || s_we[3] !== 1'b0 || s_oe[1] !== 1'b1 || s_addr[1] !== 18'd0 ||
        s_addr[3] !== 18'd1) begin
      miscompares++;
      $display("FAIL both_phase: we_n=%b/%b oe_n=%b addr=%0d/%0d want 0/0 1 0/1", s_we[1],
               s_we[3], s_oe[1], s_addr[1], s_addr[3]);
    end
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    next_cycle();
    vectors++;
    if (mem[0] !== 16'h2222 || mem[1] !== 16'h1111 || read_data !== 32'h56781234) begin
      miscompares++;
      $display("FAIL both_result: mem0=%h mem1=%h rd=%h want 2222 1111 56781234", mem[0],
               mem[1], read_data);
    end
  endtask

  task automatic test_reset_mid_access();
    mem_w_en = 1'b1; alu_result = 32'd1028; st_val = 32'h0BADCAFE;
    for (int i = 0; i < 3; i++) next_cycle();
    vectors++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd3 || sram_dq_out !== 16'h0BAD) begin
      miscompares++;
      $display("FAIL mid_high: we_n=%b addr=%0d dq=%h want 0 3 0bad", sram_we_n, sram_addr,
               sram_dq_out);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_oe_n !== 1'b1 ||
        read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: we_n=%b dq_oe=%b oe_n=%b rd=%h want 1 0 1 0", sram_we_n,
               sram_dq_oe, sram_oe_n, read_data);
    end
    mem_w_en = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    vectors++;
    if (ready !== 1'b1 || mem[2] !== 16'hCAFE || mem[3] !== 16'hDEAD) begin
      miscompares++;
      $display("FAIL mid_after: ready=%b mem2=%h mem3=%h want 1 cafe dead", ready, mem[2],
               mem[3]);
    end
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    vectors++;
    if (s_ready[0] !== 1'b0 || s_ready[4] !== 1'b0 || s_ready[5] !== 1'b1 ||
        s_rd[5] !== 32'hDEADCAFE) begin
      miscompares++;
      $display("FAIL mid_reload: ready=%b%b%b rd=%h want 001 deadcafe", s_ready[0], s_ready[4],
               s_ready[5], s_rd[5]);
    end
    mem_r_en = 1'b0;
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_both_enables();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
